// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns EX/MEM load/store control into a req/gnt/rvalid
// data-memory transaction and returns aligned, extended load data to MEM/WB.
module mem_access_stage #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic [WIDTH-1:0] mem_data,
  output logic             stall,
  output logic             misaligned_err,
  output logic             bus_err,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [2:0]       state
);

  // Handshake: dmem_req/we/addr/be/wdata stay stable from the cycle req rises
  // until the cycle dmem_gnt is sampled high; req drops the cycle after gnt.
  // A load's data returns on dmem_rvalid, no earlier than one cycle after gnt.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT_R = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  state_t           fsm, fsm_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] mem_data_n, addr_n, wdata_n;
  logic             mis_n, bus_n, req_n, we_n;
  logic [3:0]       be_n;
  logic [2:0]       ld_f3, ld_f3_n;
  logic [1:0]       ld_lane, ld_lane_n;
  logic             access, misaligned, timeout;

  assign state      = fsm;
  assign access     = (mem_rd | mem_wr) & ~flush;
  assign misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                      ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign timeout    = (cnt == TMAX);
  assign stall      = ((fsm == IDLE) & access & ~misaligned) |
                      (fsm == REQ) | (fsm == WAIT_R) | (fsm == DRAIN);

  // Lane extraction uses the funct3/lane captured at issue, not the live
  // inputs, so the returned word is formatted for the instruction that asked.
  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [2:0]  f3,
                                          input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   extract = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   extract = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  always_comb begin
    fsm_n      = fsm;
    cnt_n      = cnt;
    mem_data_n = mem_data;
    mis_n      = 1'b0;
    bus_n      = 1'b0;
    req_n      = dmem_req;
    we_n       = dmem_we;
    addr_n     = dmem_addr;
    be_n       = dmem_be;
    wdata_n    = dmem_wdata;
    ld_f3_n    = ld_f3;
    ld_lane_n  = ld_lane;
    case (fsm)
      IDLE: begin
        cnt_n = '0;
        if (access) begin
          if (misaligned) begin
            mis_n = 1'b1;
          end else begin
            fsm_n     = REQ;
            req_n     = 1'b1;
            we_n      = mem_wr;
            addr_n    = {addr[WIDTH-1:2], 2'b00};
            ld_f3_n   = funct3;
            ld_lane_n = addr[1:0];
            be_n      = 4'b1111;
            wdata_n   = '0;
            if (mem_wr) begin
              case (funct3[1:0])
                2'b00: begin
                  be_n    = 4'b0001 << addr[1:0];
                  wdata_n = {4{store_data[7:0]}};
                end
                2'b01: begin
                  be_n    = 4'b0011 << addr[1:0];
                  wdata_n = {2{store_data[15:0]}};
                end
                default: wdata_n = store_data;
              endcase
            end
          end
        end
      end
      REQ: begin
        cnt_n = cnt + CW'(1);
        if (dmem_gnt) begin
          req_n = 1'b0;
          if (dmem_we) fsm_n = flush ? IDLE : DONE;
          else         fsm_n = flush ? DRAIN : WAIT_R;
        end else if (flush) begin
          req_n = 1'b0;
          fsm_n = IDLE;
        end else if (timeout) begin
          req_n      = 1'b0;
          bus_n      = 1'b1;
          mem_data_n = '0;
          fsm_n      = DONE;
        end
      end
      WAIT_R: begin
        cnt_n = cnt + CW'(1);
        if (flush) begin
          fsm_n = dmem_rvalid ? IDLE : DRAIN;
        end else if (dmem_rvalid) begin
          mem_data_n = extract(dmem_rdata, ld_f3, ld_lane);
          fsm_n      = DONE;
        end else if (timeout) begin
          bus_n      = 1'b1;
          mem_data_n = '0;
          fsm_n      = DONE;
        end
      end
      DRAIN: begin
        cnt_n = cnt + CW'(1);
        if (dmem_rvalid || timeout) fsm_n = IDLE;
      end
      DONE: begin
        cnt_n = '0;
        fsm_n = IDLE;
      end
      default: fsm_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm            <= IDLE;
      cnt            <= '0;
      mem_data       <= '0;
      misaligned_err <= 1'b0;
      bus_err        <= 1'b0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_be        <= 4'b0000;
      dmem_wdata     <= '0;
      ld_f3          <= 3'b000;
      ld_lane        <= 2'b00;
    end else begin
      fsm            <= fsm_n;
      cnt            <= cnt_n;
      mem_data       <= mem_data_n;
      misaligned_err <= mis_n;
      bus_err        <= bus_n;
      dmem_req       <= req_n;
      dmem_we        <= we_n;
      dmem_addr      <= addr_n;
      dmem_be        <= be_n;
      dmem_wdata     <= wdata_n;
      ld_f3          <= ld_f3_n;
      ld_lane        <= ld_lane_n;
    end
  end

endmodule
